uart_hex_display: RTL and testbench



---
 rtl/uart_disp_pkg.sv | 45 ++++
 rtl/uart_rx_core.sv | 132 +++++++++++++
 rtl/uart_hex_display.sv | 62 ++++++
 tb/tb_uart_hex_display.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_disp_pkg.sv
// Shared types and the 7-segment decode for the UART-to-hex display path.
package uart_disp_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // Active-low segments, gfedcba order.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = SEG_ZERO;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: rx synchroniser, frame FSM, parity/stop checking.
module uart_rx_core
  import uart_disp_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50,
  parameter int unsigned BIT_RATE    = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_vld,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ * 1000000 / BIT_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
  localparam parity_e     PMODE        = parity_e'(PARITY_MODE[1:0]);

  rx_state_e      state;
  logic           s1, s2, prev, warm1, warm2;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitcnt;
  logic [7:0]     sreg;
  logic           stop_bad, par_bad;
  logic           fall, bit_tick, half_tick;

  assign fall      = prev & ~s2;
  assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt == CW'(HALF_BIT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      prev      <= 1'b0;
      warm1     <= 1'b0;
      warm2     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      sreg      <= '0;
      stop_bad  <= 1'b0;
      par_bad   <= 1'b0;
      data      <= '0;
      data_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1        <= rx;
      s2        <= s1;
      // prev only follows s2 once s2 holds a real line sample, so a line
      // held low through reset release never looks like a falling edge.
      warm1     <= 1'b1;
      warm2     <= warm1;
      prev      <= warm2 & s2;
      data_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          bitcnt <= '0;
          if (fall) begin
            state    <= START;
            sreg     <= '0;
            stop_bad <= 1'b0;
            par_bad  <= 1'b0;
          end
        end
        START: begin
          if (half_tick) begin
            cnt   <= '0;
            state <= s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt          <= '0;
            sreg[bitcnt] <= s2;
            if (bitcnt == 3'(DATA_BITS - 1)) begin
              bitcnt <= '0;
              state  <= (PMODE == PAR_NONE) ? STOP : PARITY;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_bad <= (^sreg) ^ s2 ^ (PMODE == PAR_ODD);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt      <= '0;
            stop_bad <= stop_bad | ~s2;
            if (bitcnt == 3'(STOP_BITS - 1)) begin
              bitcnt <= '0;
              if (stop_bad | ~s2 | par_bad) begin
                frame_err <= 1'b1;
              end else begin
                data     <= sreg;
                data_vld <= 1'b1;
              end
              state <= (stop_bad | ~s2) ? WAIT_IDLE : IDLE;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_display.sv
// UART receiver feeding a scrolling bank of active-low 7-segment hex digits.
module uart_hex_display
  import uart_disp_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50,
  parameter int unsigned BIT_RATE    = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    err_led,
  output logic                    byte_stb
);

  logic [7:0] data;
  logic       data_vld, frame_err;
  logic [3:0] dig [NUM_DIGITS];

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BIT_RATE   (BIT_RATE),
    .DATA_BITS  (DATA_BITS),
    .PARITY_MODE(PARITY_MODE),
    .STOP_BITS  (STOP_BITS)
  ) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .data     (data),
    .data_vld (data_vld),
    .frame_err(frame_err)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) dig[k] <= '0;
      err_led  <= 1'b0;
      byte_stb <= 1'b0;
    end else begin
      byte_stb <= data_vld;
      if (data_vld) begin
        for (int unsigned k = 2; k < NUM_DIGITS; k++) dig[k] <= dig[k-2];
        dig[1]  <= data[7:4];
        dig[0]  <= data[3:0];
        err_led <= 1'b0;
      end else if (frame_err) begin
        err_led <= 1'b1;
      end
    end
  end

  always_comb begin
    hex = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) hex[7*k +: 7] = hex_to_seg7(dig[k]);
  end

endmodule

// File: tb/tb_uart_hex_display.sv
// Directed bench: 8N1 display instance plus an even-parity instance on a shared reset.
module tb_uart_hex_display;

  localparam int unsigned CPB = 10;  // 1 MHz / 100 kbit/s

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx, rxp;
  logic [27:0] hex, hexp;
  logic        err, errp, stb, stbp;

  int checks   = 0;
  int failures = 0;
  int stb_cnt  = 0;
  int stbp_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stb)  stb_cnt++;
    if (stbp) stbp_cnt++;
  end

  uart_hex_display #(
    .CLK_FREQ(1), .BIT_RATE(100000), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1), .NUM_DIGITS(4)
  ) u_dut (
    .clk(clk), .resetn(resetn), .rx(rx),
    .hex(hex), .err_led(err), .byte_stb(stb)
  );

  uart_hex_display #(
    .CLK_FREQ(1), .BIT_RATE(100000), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1), .NUM_DIGITS(4)
  ) u_dutp (
    .clk(clk), .resetn(resetn), .rx(rxp),
    .hex(hexp), .err_led(errp), .byte_stb(stbp)
  );

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, optional parity, one stop bit.
  task automatic send_frame(input logic [7:0] b, input bit to_p, input bit has_par,
                            input bit par, input bit stop);
    logic [10:0] bits;
    int n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    n = 9;
    if (has_par) begin
      bits[9] = par;
      n = 10;
    end
    bits[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      if (to_p) rxp = bits[i];
      else      rx  = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int s0, sp0;
    resetn = 1'b0; rx = 1'b1; rxp = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (hex !== {4{7'b1000000}}) begin failures++; $display("FAIL reset_hex got=%h exp=%h", hex, {4{7'b1000000}}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", stb); end
    resetn = 1'b1;
    idle_bits(2);
    checks++; if (hex !== {4{7'b1000000}}) begin failures++; $display("FAIL post_reset_hex got=%h exp=%h", hex, {4{7'b1000000}}); end
    // Line held low across reset release.
    resetn = 1'b0; rx = 1'b0; rxp = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    s0 = stb_cnt; sp0 = stbp_cnt;
    idle_bits(30);
    checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL low_release_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (stbp_cnt - sp0 !== 0) begin failures++; $display("FAIL low_release_stbp got=%0d exp=0", stbp_cnt - sp0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL low_release_err got=%b exp=0", err); end
    checks++; if (errp !== 1'b0) begin failures++; $display("FAIL low_release_errp got=%b exp=0", errp); end
    rx = 1'b1; rxp = 1'b1;
    idle_bits(2);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL low_release_err2 got=%b exp=0", err); end
  endtask

  task automatic test_single;
    int s0;
    s0 = stb_cnt;
    send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL single_stb_count got=%0d exp=1", stb_cnt - s0); end
    checks++; if (hex !== {7'h40, 7'h40, 7'h30, 7'h08}) begin failures++; $display("FAIL single_hex got=%h exp=%h", hex, {7'h40, 7'h40, 7'h30, 7'h08}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
  endtask

  task automatic test_back_to_back;
    int s0;
    s0 = stb_cnt;
    send_frame(8'h5F, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (stb_cnt - s0 !== 2) begin failures++; $display("FAIL b2b_stb_count got=%0d exp=2", stb_cnt - s0); end
    checks++; if (hex !== {7'h12, 7'h0E, 7'h30, 7'h08}) begin failures++; $display("FAIL b2b_hex got=%h exp=%h", hex, {7'h12, 7'h0E, 7'h30, 7'h08}); end
    s0 = stb_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL scroll_stb_count got=%0d exp=1", stb_cnt - s0); end
    checks++; if (hex !== {7'h30, 7'h08, 7'h40, 7'h40}) begin failures++; $display("FAIL scroll_hex got=%h exp=%h", hex, {7'h30, 7'h08, 7'h40, 7'h40}); end
  endtask

  task automatic test_parity;
    int s0;
    s0 = stbp_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (stbp_cnt - s0 !== 1) begin failures++; $display("FAIL par_good_stb got=%0d exp=1", stbp_cnt - s0); end
    checks++; if (hexp !== {7'h40, 7'h40, 7'h08, 7'h12}) begin failures++; $display("FAIL par_good_hex got=%h exp=%h", hexp, {7'h40, 7'h40, 7'h08, 7'h12}); end
    checks++; if (errp !== 1'b0) begin failures++; $display("FAIL par_good_err got=%b exp=0", errp); end
    s0 = stbp_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    checks++; if (errp !== 1'b1) begin failures++; $display("FAIL par_bad_err got=%b exp=1", errp); end
    checks++; if (stbp_cnt - s0 !== 0) begin failures++; $display("FAIL par_bad_stb got=%0d exp=0", stbp_cnt - s0); end
    checks++; if (hexp !== {7'h40, 7'h40, 7'h08, 7'h12}) begin failures++; $display("FAIL par_bad_hex got=%h exp=%h", hexp, {7'h40, 7'h40, 7'h08, 7'h12}); end
    send_frame(8'h3A, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (errp !== 1'b0) begin failures++; $display("FAIL par_recover_err got=%b exp=0", errp); end
    checks++; if (hexp !== {7'h08, 7'h12, 7'h30, 7'h08}) begin failures++; $display("FAIL par_recover_hex got=%h exp=%h", hexp, {7'h08, 7'h12, 7'h30, 7'h08}); end
  endtask

  task automatic test_framing;
    int s0;
    s0 = stb_cnt;
    send_frame(8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(30);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL frame_err_led got=%b exp=1", err); end
    checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL frame_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (hex !== {7'h30, 7'h08, 7'h40, 7'h40}) begin failures++; $display("FAIL frame_hex got=%h exp=%h", hex, {7'h30, 7'h08, 7'h40, 7'h40}); end
    rx = 1'b1;
    idle_bits(2);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL frame_err_hold got=%b exp=1", err); end
    s0 = stb_cnt;
    send_frame(8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (hex !== {7'h40, 7'h40, 7'h19, 7'h79}) begin failures++; $display("FAIL frame_recover_hex got=%h exp=%h", hex, {7'h40, 7'h40, 7'h19, 7'h79}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL frame_recover_err got=%b exp=0", err); end
    checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL frame_recover_stb got=%0d exp=1", stb_cnt - s0); end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = stb_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    idle_bits(20);
    checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL glitch_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b exp=0", err); end
    checks++; if (hex !== {7'h40, 7'h40, 7'h19, 7'h79}) begin failures++; $display("FAIL glitch_hex got=%h exp=%h", hex, {7'h40, 7'h40, 7'h19, 7'h79}); end
  endtask

  task automatic test_reset_mid;
    int s0;
    // Leave err_led set so the mid-frame reset has something to clear.
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    idle_bits(2);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL mid_pre_err got=%b exp=1", err); end
    rx = 1'b0; idle_bits(1);
    rx = 1'b1; idle_bits(3);
    rx = 1'b0; repeat (CPB / 2) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (hex !== {4{7'b1000000}}) begin failures++; $display("FAIL mid_reset_hex got=%h exp=%h", hex, {4{7'b1000000}}); end
    checks++; if (hexp !== {4{7'b1000000}}) begin failures++; $display("FAIL mid_reset_hexp got=%h exp=%h", hexp, {4{7'b1000000}}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_reset_err got=%b exp=0", err); end
    rx = 1'b1;
    resetn = 1'b1;
    s0 = stb_cnt;
    idle_bits(20);
    checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL mid_after_stb got=%0d exp=0", stb_cnt - s0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_after_err got=%b exp=0", err); end
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    checks++; if (hex !== {7'h40, 7'h40, 7'h78, 7'h78}) begin failures++; $display("FAIL mid_clean_hex got=%h exp=%h", hex, {7'h40, 7'h40, 7'h78, 7'h78}); end
    checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL mid_clean_stb got=%0d exp=1", stb_cnt - s0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_parity;
    test_framing;
    test_glitch;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
